gate_bist: RTL and testbench
============================

GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 1, cycles each vector is driven before the output is sampled (legal range 1..15).
REQ-002 SHALL have parameter: PASSES, 1, number of full 4-vector sweeps per run (legal range 1..255).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: start  input  1  run request, level-sampled in IDLE.
REQ-006 SHALL have ports: dut_a  output  1, and dut_b  output  1  registered stimulus to the 2-input AND gate under test.
REQ-007 SHALL have port: dut_y  input  1  output of the gate under test.
REQ-008 SHALL have port: busy  output  1  high in APPLY and CHECK.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: pass  output  1  run result; valid from done until the next accepted start.
REQ-011 SHALL have port: err_cnt  output  8  mismatch count, saturating.

Function
REQ-012 SHALL implement FSM states IDLE, APPLY, CHECK and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL:
- clear err_cnt, pass, the vector index and the pass counter;
- enter APPLY with {dut_a,dut_b}=2'b00.
REQ-014 APPLY SHALL hold the vector for exactly SETTLE_CYCLES cycles, then enter CHECK.
REQ-015 CHECK SHALL last one cycle, sample dut_y, and compare it with the expected value dut_a & dut_b.
REQ-016 On mismatch, CHECK SHALL increment err_cnt; err_cnt SHALL hold at 255 (no wrap).
REQ-017 After CHECK, the vector index SHALL advance 00->01->10->11, then wrap to 00 and increment the pass counter.
REQ-018 After CHECK of vector 11 in pass PASSES-1, the FSM SHALL enter DONE instead of APPLY.
REQ-019 done SHALL be a Moore output, high only in DONE, asserted exactly 4*PASSES*(SETTLE_CYCLES+1) rising edges after the edge that accepted start.
REQ-020 On entry to DONE, pass SHALL be set to (err_cnt==0), including any mismatch found in the final CHECK.
REQ-021 DONE SHALL return to IDLE on the next edge regardless of start; start seen in DONE SHALL NOT begin a run.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 pass and err_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-024 dut_a and dut_b SHALL be 0 in IDLE and DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, independent of clk:
- state IDLE;
- dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_cnt=0;
- all internal counters to 0.
REQ-026 Reset asserted during a run SHALL abort it with no done pulse; the first start after release SHALL begin a fresh run.

Configuration
REQ-027 With macro GATE_BIST_FAILCAP_EN defined, the module SHALL add ports fail_vec (output, 2 bits) and fail_valid (output, 1 bit).
REQ-028 With GATE_BIST_FAILCAP_EN defined:
- fail_vec SHALL capture {dut_a,dut_b} of the first mismatch in a run, and fail_valid SHALL be set to 1;
- later mismatches SHALL NOT change fail_vec;
- both SHALL clear on accepted start and on reset.
REQ-029 Without GATE_BIST_FAILCAP_EN, the module SHALL have neither port nor their logic; all other behaviour SHALL be identical.

Verification
REQ-030 Correct AND model on dut_y, SETTLE_CYCLES=1, PASSES=1, start pulsed -> done high 8 edges later; pass=1; err_cnt=0; fail_valid=0.
REQ-031 dut_y stuck at 0 -> err_cnt=1; pass=0; fail_vec=2'b11.
REQ-032 dut_y stuck at 1, PASSES=100 -> raw mismatch count 300; err_cnt=255 (saturated); fail_vec=2'b00; done after 800 edges.
REQ-033 SETTLE_CYCLES=3: the vector changes only on CHECK exit; done after 16 edges; start held high throughout the run -> exactly one run.
REQ-034 rst_n pulsed low during CHECK of vector 10 -> all outputs 0 immediately; no done; the next start completes a correct run with pass=1.

Source files
------------

// File: rtl/gate_bist.sv
// Built-in self test for a 2-input AND gate: sweeps all four input vectors PASSES times and counts mismatches.
// Optional first-failure capture ports are enabled by defining GATE_BIST_FAILCAP_EN.
module gate_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt
`ifdef GATE_BIST_FAILCAP_EN
    ,
    output logic [1:0] fail_vec,
    output logic       fail_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] vec_idx;
    logic [7:0] pass_cnt;
    logic       mismatch;
    logic       last_vec;
    logic [7:0] err_next;

    assign mismatch = (dut_y != (dut_a & dut_b));
    assign last_vec = (vec_idx == 2'b11) && (pass_cnt == 8'(PASSES - 1));

    // Saturating count so a badly broken gate cannot wrap back to a clean-looking value
    always_comb begin
        err_next = err_cnt;
        if (mismatch && (err_cnt != 8'hFF)) begin
            err_next = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            vec_idx    <= 2'd0;
            pass_cnt   <= 8'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 8'd0;
`ifdef GATE_BIST_FAILCAP_EN
            fail_vec   <= 2'b00;
            fail_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= APPLY;
                        settle_cnt <= 4'd0;
                        vec_idx    <= 2'd0;
                        pass_cnt   <= 8'd0;
                        dut_a      <= 1'b0;
                        dut_b      <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_cnt    <= 8'd0;
`ifdef GATE_BIST_FAILCAP_EN
                        fail_vec   <= 2'b00;
                        fail_valid <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= 4'd0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
`ifdef GATE_BIST_FAILCAP_EN
                    if (mismatch && !fail_valid) begin
                        fail_vec   <= {dut_a, dut_b};
                        fail_valid <= 1'b1;
                    end
`endif
                    // pass uses err_next so a mismatch on the final vector still counts
                    if (last_vec) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_next == 8'd0);
                        dut_a    <= 1'b0;
                        dut_b    <= 1'b0;
                        vec_idx  <= 2'd0;
                        pass_cnt <= 8'd0;
                    end else begin
                        state   <= APPLY;
                        vec_idx <= vec_idx + 2'd1;
                        {dut_a, dut_b} <= vec_idx + 2'd1;
                        if (vec_idx == 2'b11) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    dut_a <= 1'b0;
                    dut_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (short and long sweeps) driven by a
// gate model with randomly chosen faulty vectors, compared against a run-level reference model.
module tb_gate_bist;

    localparam int S0 = 1;
    localparam int P0 = 1;
    localparam int S1 = 3;
    localparam int P1 = 100;

    logic       clk;
    logic       rst_n;
    logic       start_s [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       y_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [7:0] err_s   [2];
    logic [3:0] mask_s  [2];
`ifdef GATE_BIST_FAILCAP_EN
    logic [1:0] fvec_s  [2];
    logic       fval_s  [2];
`endif

    int checks;
    int failures;

    gate_bist #(.SETTLE_CYCLES(S0), .PASSES(P0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s[0]),
        .dut_a   (a_s[0]),
        .dut_b   (b_s[0]),
        .dut_y   (y_s[0]),
        .busy    (busy_s[0]),
        .done    (done_s[0]),
        .pass    (pass_s[0]),
        .err_cnt (err_s[0])
`ifdef GATE_BIST_FAILCAP_EN
        ,
        .fail_vec   (fvec_s[0]),
        .fail_valid (fval_s[0])
`endif
    );

    gate_bist #(.SETTLE_CYCLES(S1), .PASSES(P1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s[1]),
        .dut_a   (a_s[1]),
        .dut_b   (b_s[1]),
        .dut_y   (y_s[1]),
        .busy    (busy_s[1]),
        .done    (done_s[1]),
        .pass    (pass_s[1]),
        .err_cnt (err_s[1])
`ifdef GATE_BIST_FAILCAP_EN
        ,
        .fail_vec   (fvec_s[1]),
        .fail_valid (fval_s[1])
`endif
    );

    // Gate under test: a true AND, with the output inverted on every vector whose mask bit is set
    assign y_s[0] = (a_s[0] & b_s[0]) ^ mask_s[0][{a_s[0], b_s[0]}];
    assign y_s[1] = (a_s[1] & b_s[1]) ^ mask_s[1][{a_s[1], b_s[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int w);
        return (w == 0) ? S0 : S1;
    endfunction

    function automatic int passes_of(input int w);
        return (w == 0) ? P0 : P1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run on instance w; called and returns just after a rising edge
    task automatic applyStimulus(input int w, input logic [3:0] mask, input bit hold);
        int s, p, n, exp_err, bad, first_bad, vec;
        logic [1:0] exp_fvec;
        s = settle_of(w);
        p = passes_of(w);
        n = 4 * p * (s + 1);
        exp_err = $countones(mask) * p;
        if (exp_err > 255) exp_err = 255;
        exp_fvec = 2'b00;
        for (int v = 3; v >= 0; v--) begin
            if (mask[v]) exp_fvec = 2'(v);
        end
        mask_s[w] = mask;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        start_s[w] = 1'b1;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k <= n + 2; k++) begin
            @(posedge clk);
            #1;
            if (k < n) begin
                vec = (k / (s + 1)) % 4;
                if ({busy_s[w], done_s[w], a_s[w], b_s[w]} !== {1'b1, 1'b0, 2'(vec)}) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
                if (!hold) start_s[w] = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (k == n) begin
                checkOutput($sformatf("i%0d_done_pulse", w), done_s[w], 1'b1);
                checkOutput($sformatf("i%0d_busy_in_done", w), busy_s[w], 1'b0);
                checkOutput($sformatf("i%0d_ab_in_done", w), {a_s[w], b_s[w]}, 2'b00);
                checkOutput($sformatf("i%0d_pass", w), pass_s[w], (mask == 4'd0));
                checkOutput($sformatf("i%0d_err_cnt", w), err_s[w], exp_err);
`ifdef GATE_BIST_FAILCAP_EN
                checkOutput($sformatf("i%0d_fail_valid", w), fval_s[w], (mask != 4'd0));
                checkOutput($sformatf("i%0d_fail_vec", w), fvec_s[w], exp_fvec);
`endif
            end else begin
                checkOutput($sformatf("i%0d_done_low_k%0d", w, k - n), done_s[w], 1'b0);
                checkOutput($sformatf("i%0d_idle_busy_k%0d", w, k - n), busy_s[w], 1'b0);
                checkOutput($sformatf("i%0d_pass_hold", w), pass_s[w], (mask == 4'd0));
                checkOutput($sformatf("i%0d_err_hold", w), err_s[w], exp_err);
                if (k == n + 1) start_s[w] = 1'b0;
            end
        end
        if (bad != 0) $display("[TB] instance %0d first bad run cycle %0d", w, first_bad);
        checkOutput($sformatf("i%0d_vector_sequence", w), bad, 0);
    endtask

    initial begin
        int seen;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        mask_s[0] = 4'd0;
        mask_s[1] = 4'd0;
        #12;
        for (int w = 0; w < 2; w++) begin
            checkOutput($sformatf("i%0d_reset_outputs", w),
                        {a_s[w], b_s[w], busy_s[w], done_s[w], pass_s[w], err_s[w]}, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] short instance: clean gate, stuck-at-0, random faults");
        applyStimulus(0, 4'b0000, 1'b0);
        applyStimulus(0, 4'b1000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during CHECK of vector 10");
        applyStimulus(0, 4'b0000, 1'b0);
        start_s[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            start_s[0] = 1'b0;
        end
        checkOutput("pre_reset_state", {busy_s[0], a_s[0], b_s[0]}, 3'b110);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0]}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done_s[0] || busy_s[0]) seen++;
        end
        checkOutput("no_run_after_abort", seen, 0);
        applyStimulus(0, 4'b0000, 1'b0);

        $display("[TB] long instance: held start, stuck-at-1 saturation, random faults");
        applyStimulus(1, 4'b0000, 1'b1);
        applyStimulus(1, 4'b0111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
